// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - saturating score/combo accumulator with per-frame BCD publish
module score_keeper #(
    parameter int NUM_LANES  = 5,
    parameter int SCORE_W    = 17,
    parameter int MAX_SCORE  = 99999,
    parameter int HIT_POINTS = 10,
    parameter int COMBO_STEP = 10,
    parameter int MAX_MULT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_start,
    input  logic [NUM_LANES-1:0] hit,
    input  logic [NUM_LANES-1:0] miss,
    input  logic                 frame_start,
    output logic [SCORE_W-1:0]   score,
    output logic [19:0]          digits,
    output logic [7:0]           combo,
    output logic [2:0]           mult,
    output logic                 busy
);

    localparam int SUM_W = SCORE_W + 1;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int POP_W = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        PUBLISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_LANES-1:0] eff_hits;
    logic [POP_W-1:0]     pop;
    logic [SUM_W-1:0]     add_pts;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;
    logic [8:0]           combo_sum;
    logic [7:0]           combo_next;
    logic [7:0]           step_cnt;
    logic [2:0]           mult_next;

    logic [SCORE_W-1:0]   bin_sr;
    logic [19:0]          bcd;
    logic [19:0]          bcd_adj;
    logic [SCORE_W+19:0]  dd_shift;
    logic [CNT_W-1:0]     bit_cnt;

    // A lane flagged both hit and miss in one cycle is a miss only.
    assign eff_hits = hit & ~miss;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pop = pop + POP_W'(eff_hits[i]);
        end
    end

    // Points use the multiplier registered before this cycle's combo change.
    assign add_pts    = SUM_W'(pop) * SUM_W'(HIT_POINTS) * SUM_W'(mult);
    assign score_sum  = SUM_W'(score) + add_pts;
    assign score_next = (score_sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                        : score_sum[SCORE_W-1:0];

    assign combo_sum  = 9'(combo) + 9'(pop);
    assign combo_next = (|miss) ? 8'd0
                      : (combo_sum > 9'd255) ? 8'hff : combo_sum[7:0];

    assign step_cnt   = combo_next / 8'(COMBO_STEP);
    assign mult_next  = (step_cnt >= 8'(MAX_MULT - 1)) ? 3'(MAX_MULT)
                                                       : 3'(step_cnt) + 3'd1;

    // Double-dabble: bias every nibble >= 5 before each left shift.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 5; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    assign dd_shift = {bcd_adj, bin_sr} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = CONVERT;
            CONVERT: if (bit_cnt == CNT_W'(SCORE_W - 1)) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (game_start) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score   <= '0;
            combo   <= '0;
            mult    <= 3'd1;
            digits  <= '0;
            bin_sr  <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
        end else if (game_start) begin
            score   <= '0;
            combo   <= '0;
            mult    <= 3'd1;
            digits  <= '0;
            bin_sr  <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
        end else begin
            score <= score_next;
            combo <= combo_next;
            mult  <= mult_next;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        bin_sr  <= score;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONVERT: begin
                    {bcd, bin_sr} <= dd_shift;
                    bit_cnt       <= bit_cnt + CNT_W'(1);
                end
                PUBLISH: begin
                    digits <= bcd;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed and random checks of score_keeper against a decimal model
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        game_start;
    logic [4:0]  hit;
    logic [4:0]  miss;
    logic        frame_start;
    logic [16:0] score;
    logic [19:0] digits;
    logic [7:0]  combo;
    logic [2:0]  mult;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int          m_score;
    int          m_combo;
    int          busy_cnt;
    int          snap;
    logic [19:0] m_digits;

    score_keeper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_start  (game_start),
        .hit         (hit),
        .miss        (miss),
        .frame_start (frame_start),
        .score       (score),
        .digits      (digits),
        .combo       (combo),
        .mult        (mult),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic int mult_of(input int c);
        return 1 + ((c / 10 > 3) ? 3 : c / 10);
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] d;
        int          pw;
        d  = '0;
        pw = 1;
        for (int k = 0; k < 5; k++) begin
            d[4*k +: 4] = 4'((v / pw) % 10);
            pw = pw * 10;
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_score  = 0;
        m_combo  = 0;
        busy_cnt = 0;
        snap     = 0;
        m_digits = '0;
    endtask

    task automatic model_tick(input logic [4:0] h, input logic [4:0] m, input logic fs, input logic gs);
        int p;
        if (gs) begin
            model_reset();
            return;
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) m_digits = to_bcd(snap);
        end else if (fs) begin
            snap     = m_score;
            busy_cnt = 18;
        end
        p       = $countones(h & ~m);
        m_score = m_score + p * 10 * mult_of(m_combo);
        if (m_score > 99999) m_score = 99999;
        if (m != 0) m_combo = 0;
        else m_combo = (m_combo + p > 255) ? 255 : m_combo + p;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, 32'(score), m_score);
        chk({tag, ".combo"}, 32'(combo), m_combo);
        chk({tag, ".mult"}, 32'(mult), mult_of(m_combo));
        chk({tag, ".busy"}, 32'(busy), 32'(busy_cnt > 0));
        chk({tag, ".digits"}, 32'(digits), 32'(m_digits));
        chk({tag, ".score_max"}, 32'(score <= 17'd99999), 1);
        for (int k = 0; k < 5; k++) begin
            chk({tag, ".nibble"}, 32'(digits[4*k +: 4] <= 4'd9), 1);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] h, input logic [4:0] m,
                        input logic fs, input logic gs);
        hit = h; miss = m; frame_start = fs; game_start = gs;
        @(posedge clk);
        model_tick(h, m, fs, gs);
        @(negedge clk);
        hit = '0; miss = '0; frame_start = 1'b0; game_start = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int prev;
        rst_n = 1'b0; hit = '0; miss = '0; frame_start = 1'b0; game_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step("warm", 5'b00011, 5'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.score", 32'(score), 0);
        chk("rst.digits", 32'(digits), 0);
        chk("rst.combo", 32'(combo), 0);
        chk("rst.mult", 32'(mult), 1);
        chk("rst.busy", 32'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) step("idle", 5'b0, 5'b0, 1'b0, 1'b0);
        chk("idle.score", 32'(score), 0);
        chk("idle.mult", 32'(mult), 1);

        // Single hit and publish latency
        step("single", 5'b00001, 5'b0, 1'b0, 1'b0);
        chk("single.score", 32'(score), 10);
        chk("single.combo", 32'(combo), 1);
        step("conv", 5'b0, 5'b0, 1'b1, 1'b0);
        chk("conv.busy0", 32'(busy), 1);
        for (int i = 1; i < 18; i++) begin
            step("conv", 5'b0, 5'b0, 1'b0, 1'b0);
            chk("conv.busy", 32'(busy), 1);
            chk("conv.hold", 32'(digits), 0);
        end
        step("conv", 5'b0, 5'b0, 1'b0, 1'b0);
        chk("conv.done", 32'(busy), 0);
        chk("conv.digits", 32'(digits), 32'h00010);

        // Multiplier step
        step("gs", 5'b0, 5'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 11; i++) begin
            step("mstep", 5'(1 << (i % 5)), 5'b0, 1'b0, 1'b0);
            if (i == 10) begin
                chk("mstep.score10", 32'(score), 100);
                chk("mstep.mult10", 32'(mult), 2);
            end
            step("mstep", 5'b0, 5'b0, 1'b0, 1'b0);
        end
        chk("mstep.score11", 32'(score), 120);
        chk("mstep.combo11", 32'(combo), 11);
        step("mstep", 5'b0, 5'b0, 1'b1, 1'b0);
        repeat (18) step("mstep", 5'b0, 5'b0, 1'b0, 1'b0);
        chk("mstep.digits", 32'(digits), 32'h00120);

        // Same-lane hit and miss
        step("gs", 5'b0, 5'b0, 1'b0, 1'b1);
        repeat (3) step("simul", 5'b00010, 5'b0, 1'b0, 1'b0);
        step("simul", 5'b10101, 5'b00100, 1'b0, 1'b0);
        chk("simul.score", 32'(score), 50);
        chk("simul.combo", 32'(combo), 0);
        chk("simul.mult", 32'(mult), 1);

        // Saturation
        step("gs", 5'b0, 5'b0, 1'b0, 1'b1);
        prev = -1;
        for (int i = 0; i < 3000; i++) begin
            prev = int'(score);
            step("sat", 5'b11111, 5'b0, 1'b0, 1'b0);
            if (prev == int'(score) && i > 300) break;
        end
        chk("sat.score", 32'(score), 99999);
        chk("sat.combo", 32'(combo), 255);
        chk("sat.mult", 32'(mult), 4);
        step("sat", 5'b0, 5'b0, 1'b1, 1'b0);
        repeat (18) step("sat", 5'b11111, 5'b0, 1'b0, 1'b0);
        chk("sat.digits", 32'(digits), 32'h99999);

        // frame_start while busy is ignored
        step("gs", 5'b0, 5'b0, 1'b0, 1'b1);
        repeat (3) step("ign", 5'b00001, 5'b0, 1'b0, 1'b0);
        step("ign", 5'b0, 5'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            step("ign", (i == 5 || i == 9) ? 5'b00110 : 5'b0, 5'b0, i == 5, 1'b0);
            if (i < 18) chk("ign.hold", 32'(digits), 0);
        end
        chk("ign.digits", 32'(digits), 32'h00030);
        repeat (25) step("ign", 5'b0, 5'b0, 1'b0, 1'b0);
        chk("ign.once", 32'(digits), 32'h00030);

        // game_start aborts a conversion
        step("abort", 5'b0, 5'b0, 1'b1, 1'b0);
        repeat (6) step("abort", 5'b0, 5'b0, 1'b0, 1'b0);
        step("abort", 5'b00001, 5'b0, 1'b0, 1'b1);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.digits", 32'(digits), 0);
        chk("abort.score", 32'(score), 0);
        repeat (30) step("abort", 5'b0, 5'b0, 1'b0, 1'b0);
        chk("abort.nopub", 32'(digits), 0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] h;
            logic [4:0] m;
            h = 5'($urandom);
            m = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b0;
            step("rand", h, m, $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
